// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor.
// Each RUN cycle pushes one CHUNK-bit slice through a ripple of full_adder
// cells. The carry between slices is held in a register, so a wide add is
// done with a narrow adder over NCH = WIDTH/CHUNK cycles.
// A valid/ready handshake is used on both the request side and the result side.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  // A partial final slice would silently drop the top bits, so it is refused here
  generate
    if (WIDTH % CHUNK != 0) begin : g_badWidth
      $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_inReady;
  logic             r_outValid;

  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CHUNK-1:0] w_sumChunk;
  logic [CHUNK:0]   w_carry;

  assign w_aChunk   = r_a[r_idx*CHUNK +: CHUNK];
  assign w_bChunk   = r_b[r_idx*CHUNK +: CHUNK];
  assign w_carry[0] = r_carry;

  // One ripple of CHUNK full adders, fed by the registered inter-slice carry
  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
      full_adder u_fa (
        .i_a (w_aChunk[i]),
        .i_b (w_bChunk[i]),
        .i_c (w_carry[i]),
        .o_s (w_sumChunk[i]),
        .o_c (w_carry[i+1])
      );
    end
  endgenerate

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_overflow;

  // Control FSM and datapath registers; handshake flags are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid && r_inReady) begin
            r_a       <= a;
            r_b       <= sub ? ~b : b;
            r_carry   <= sub ? 1'b1 : cin;
            r_idx     <= '0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_sum[r_idx*CHUNK +: CHUNK] <= w_sumChunk;
          r_carry <= w_carry[CHUNK];
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout     <= w_carry[CHUNK];
            r_overflow <= w_carry[CHUNK] ^ w_carry[CHUNK-1];
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: three instances (CHUNK=4, 16, 1) share one request
// stream. Each instance must produce the same result, and each has its own
// latency.

module tb_chunked_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_ready;

  logic        inReadyA  [3];
  logic        outValidA [3];
  logic [15:0] sumA      [3];
  logic        coutA     [3];
  logic        ovA       [3];

  int checks = 0;
  int errors = 0;
  int latArr [3];

  localparam int LAT [3] = '{4, 1, 16};

  typedef struct packed {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic        vsub;
    logic [15:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyA[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValidA[0]),
    .out_ready(out_ready), .sum(sumA[0]), .cout(coutA[0]), .overflow(ovA[0])
  );

  chunked_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyA[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValidA[1]),
    .out_ready(out_ready), .sum(sumA[1]), .cout(coutA[1]), .overflow(ovA[1])
  );

  chunked_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyA[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(outValidA[2]),
    .out_ready(out_ready), .sum(sumA[2]), .cout(coutA[2]), .overflow(ovA[2])
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records the cycle (counted from the accept edge) at which each instance first shows out_valid
  task automatic waitAllDone(input int budget);
    for (int k = 0; k < 3; k++) latArr[k] = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (latArr[k] < 0 && outValidA[k] === 1'b1) latArr[k] = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inReadyA[k] !== 1'b1 || outValidA[k] !== 1'b0 || sumA[k] !== 16'h0000 ||
          coutA[k] !== 1'b0 || ovA[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d got rdy=%b vld=%b sum=%h co=%b ov=%b expected rdy=1 vld=0 sum=0000 co=0 ov=0",
                 k, inReadyA[k], outValidA[k], sumA[k], coutA[k], ovA[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t vecs [7];
    vecs[0] = '{16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (inReadyA[k] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL arith%0d_ready dut%0d got %b expected 1", v, k, inReadyA[k]);
        end
      end
      a = vecs[v].va; b = vecs[v].vb; cin = vecs[v].vcin; sub = vecs[v].vsub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~a; b = 16'hFFFF; cin = ~cin; sub = ~sub;
      waitAllDone(20);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (latArr[k] != LAT[k]) begin
          errors++;
          $display("[TB] FAIL arith%0d_latency dut%0d got %0d expected %0d", v, k, latArr[k], LAT[k]);
        end
        checks++;
        if (sumA[k] !== vecs[v].es || coutA[k] !== vecs[v].eco || ovA[k] !== vecs[v].eov) begin
          errors++;
          $display("[TB] FAIL arith%0d_result dut%0d got sum=%h co=%b ov=%b expected sum=%h co=%b ov=%b",
                   v, k, sumA[k], coutA[k], ovA[k], vecs[v].es, vecs[v].eco, vecs[v].eov);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (outValidA[k] !== 1'b0 || inReadyA[k] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL arith%0d_release dut%0d got vld=%b rdy=%b expected vld=0 rdy=1",
                   v, k, outValidA[k], inReadyA[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitAllDone(18);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (latArr[k] != LAT[k]) begin
        errors++;
        $display("[TB] FAIL bp_first_latency dut%0d got %0d expected %0d", k, latArr[k], LAT[k]);
      end
    end
    // second request offered while results are still waiting
    a = 16'h0100; b = 16'h0001; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (outValidA[k] !== 1'b1 || inReadyA[k] !== 1'b0 || sumA[k] !== 16'h3333) begin
          errors++;
          $display("[TB] FAIL bp_hold%0d dut%0d got vld=%b rdy=%b sum=%h expected vld=1 rdy=0 sum=3333",
                   c, k, outValidA[k], inReadyA[k], sumA[k]);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outValidA[k] !== 1'b0 || inReadyA[k] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_idle dut%0d got vld=%b rdy=%b expected vld=0 rdy=1",
                 k, outValidA[k], inReadyA[k]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inReadyA[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_second_accept dut%0d got rdy=%b expected 0", k, inReadyA[k]);
      end
    end
    waitAllDone(20);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (latArr[k] != LAT[k] || sumA[k] !== 16'h00FF || coutA[k] !== 1'b1 || ovA[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_second_result dut%0d got lat=%0d sum=%h co=%b ov=%b expected lat=%0d sum=00ff co=1 ov=0",
                 k, latArr[k], sumA[k], coutA[k], ovA[k], LAT[k]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h0FED; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (inReadyA[k] !== 1'b1 || outValidA[k] !== 1'b0 || sumA[k] !== 16'h0000 ||
          coutA[k] !== 1'b0 || ovA[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrun_reset dut%0d got rdy=%b vld=%b sum=%h co=%b ov=%b expected rdy=1 vld=0 sum=0000 co=0 ov=0",
                 k, inReadyA[k], outValidA[k], sumA[k], coutA[k], ovA[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    a = 16'h0007; b = 16'h0005; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitAllDone(20);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (latArr[k] != LAT[k] || sumA[k] !== 16'h0002 || coutA[k] !== 1'b1 || ovA[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrun_fresh dut%0d got lat=%0d sum=%h co=%b ov=%b expected lat=%0d sum=0002 co=1 ov=0",
                 k, latArr[k], sumA[k], coutA[k], ovA[k], LAT[k]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
